// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants for the instruction memory boot loader
//
// Holds the loader state encodings, the core's instruction word width and a
// helper that checks a requested load length against the memory depth.

package imem_loader_pkg;

  // Instruction word width used throughout the core.
  localparam int WORD_W = 32;

  // Loader state encodings (3-bit, legacy-compatible constants).
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // A load must write at least one word and must not run past the last
  // memory index, so that the write address can never wrap.
  function automatic logic len_ok(input logic [31:0] len, input logic [31:0] words);
    return (len != 32'd0) && (len <= words);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader that streams a program image into instruction memory
//
// Accepts program words on a valid/ready stream and writes them sequentially
// into the Icache external write port, keeping the core out of run mode until
// the whole image has been written.
//
// Ports:
//   PHI1       in   clock, rising-edge state updates
//   MRST       in   asynchronous active-high reset
//   Start      in   one-cycle load command
//   LoadLen    in   number of words to load, sampled with Start
//   Abort      in   cancels a load in progress
//   DataIn     in   program word
//   DataValid  in   DataIn is valid
//   DataReady  out  loader accepts a word this cycle (combinational)
//   IAddrE     out  zero-extended word index into instruction memory
//   IInE       out  word to write
//   IWriteE    out  write strobe, one cycle per word
//   CpuRun     out  core/Icache run enable
//   Busy       out  loading or flushing
//   Done       out  image loaded, core running
//   Err        out  last Start carried an invalid length
//   WordCount  out  words accepted in the current or last load
//   Checksum   out  XOR of words accepted in the current or last load

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORDS  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                PHI1,
  input  logic                MRST,
  input  logic                Start,
  input  logic [ADDR_W:0]     LoadLen,
  input  logic                Abort,
  input  logic [WORD_W-1:0]   DataIn,
  input  logic                DataValid,
  output logic                DataReady,
  output logic [WORD_W-1:0]   IAddrE,
  output logic [WORD_W-1:0]   IInE,
  output logic                IWriteE,
  output logic                CpuRun,
  output logic                Busy,
  output logic                Done,
  output logic                Err,
  output logic [ADDR_W:0]     WordCount,
  output logic [WORD_W-1:0]   Checksum
);

  logic [2:0]      state;
  logic [ADDR_W:0] load_len;
  logic [ADDR_W:0] next_count;
  logic            start_ok;
  logic            accept;

  // Words are written strictly in order starting at index 0, so the accepted
  // word count doubles as the next write address.
  assign next_count = WordCount + {{ADDR_W{1'b0}}, 1'b1};
  assign start_ok   = len_ok(32'(LoadLen), 32'(WORDS));
  assign accept     = DataValid && (state == ST_LOAD);

  // Status flags are straight decodes of the state register, so they change
  // only on a clock edge or immediately on reset.
  assign DataReady = (state == ST_LOAD);
  assign Busy      = (state == ST_LOAD) || (state == ST_FLUSH);
  assign CpuRun    = (state == ST_RUN);
  assign Done      = (state == ST_RUN);
  assign Err       = (state == ST_ERR);

  always_ff @(posedge PHI1 or posedge MRST) begin
    if (MRST) begin
      state     <= ST_IDLE;
      load_len  <= '0;
      IAddrE    <= '0;
      IInE      <= '0;
      IWriteE   <= 1'b0;
      WordCount <= '0;
      Checksum  <= '0;
    end else begin
      // The strobe is a one-cycle pulse; only an accepted word re-arms it.
      IWriteE <= 1'b0;

      case (state)
        // IDLE, RUN and ERR all react to Start the same way; leaving RUN
        // drops CpuRun on that same edge through the state decode.
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (Start) begin
            if (start_ok) begin
              state     <= ST_LOAD;
              load_len  <= LoadLen;
              WordCount <= '0;
              Checksum  <= '0;
            end else begin
              state <= ST_ERR;
            end
          end
        end

        ST_LOAD: begin
          // Abort wins over a word offered in the same cycle; words already
          // written stay in memory.
          if (Abort) begin
            state <= ST_IDLE;
          end else if (accept) begin
            IAddrE    <= {{(WORD_W-ADDR_W){1'b0}}, WordCount[ADDR_W-1:0]};
            IInE      <= DataIn;
            IWriteE   <= 1'b1;
            WordCount <= next_count;
            Checksum  <= Checksum ^ DataIn;
            if (next_count == load_len) begin
              state <= ST_FLUSH;
            end
          end
        end

        // One idle cycle so the final write is taken by the Icache at the
        // following negedge before the core is released.
        ST_FLUSH: begin
          state <= ST_RUN;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
